// File: rtl/decoder_nto2n_seq_if.sv
// Handshake/bus bundle for decoder_nto2n_seq.
// The master drives control and select and observes the decoded outputs; the slave is the decoder.
interface decoder_nto2n_seq_if #(
  parameter int unsigned N = 2
);
  localparam int unsigned W = 1 << N;

  logic         en;
  logic         mode;
  logic [N-1:0] sel;
  logic         start;
  logic         abort;
  logic [W-1:0] y;
  logic [N-1:0] y_idx;
  logic         busy;
  logic         done;

  modport master (
    output en, mode, sel, start, abort,
    input  y, y_idx, busy, done
  );

  modport slave (
    input  en, mode, sel, start, abort,
    output y, y_idx, busy, done
  );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a DIRECT decode mode and a SCAN sweep mode.
// SCAN walks the one-hot output from bit 0 to bit 2^N-1, holding each bit DWELL enabled
// cycles, then pulses done for one cycle.
// Build option: DECODER_ACTIVE_LOW_EN inverts the y port for active-low select loads;
// internal state, y_idx, busy and done are unaffected.
module decoder_nto2n_seq #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 1
) (
  input logic                clk,
  input logic                rst,
  decoder_nto2n_seq_if.slave bus
);
  localparam int unsigned W = 1 << N;
  localparam logic [W-1:0] YOne    = W'(1);
  localparam logic [N-1:0] IdxLast = N'(W - 1);
  localparam logic [7:0]   CntLast = 8'(DWELL - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e       state_q;
  logic [W-1:0] y_q;
  logic [N-1:0] idx_q;
  logic [7:0]   cnt_q;
  logic         busy_q;
  logic         done_q;

  // FSM with all outputs registered; start beats DIRECT decode, abort beats en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && bus.mode) begin
            state_q <= StScan;
            y_q     <= YOne;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (bus.en) begin
            y_q   <= YOne << bus.sel;
            idx_q <= bus.sel;
          end else begin
            // y_idx deliberately holds its last value while the output is off.
            y_q <= '0;
          end
        end
        StScan: begin
          if (bus.abort) begin
            state_q <= StIdle;
            y_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (bus.en) begin
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (idx_q == IdxLast) begin
                // Terminal index finished its dwell: end the sweep, no wrap.
                state_q <= StIdle;
                y_q     <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
                y_q   <= y_q << 1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign bus.y = ~y_q;
`else
  assign bus.y = y_q;
`endif
  assign bus.y_idx = idx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq (N=2, DWELL=3): directed scenarios pinned by
// literal expectations, then randomized traffic checked every cycle against a scan-position model.
module tb_decoder_nto2n_seq;
  localparam int unsigned N     = 2;
  localparam int unsigned DWELL = 3;
  localparam int unsigned W     = 1 << N;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  decoder_nto2n_seq_if #(.N(N)) bus ();

  decoder_nto2n_seq #(
    .N    (N),
    .DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: scan progress is the count of enabled cycles since start; index = count / DWELL.
  bit           m_scan;
  int           m_k;
  int           m_idx;
  bit           m_done;
  logic [W-1:0] m_y;

  function automatic logic [W-1:0] pin_y(input logic [W-1:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 1'b0;
    m_k    = 0;
    m_idx  = 0;
    m_done = 1'b0;
    m_y    = '0;
  endtask

  task automatic model_step(input logic e, input logic m, input logic [N-1:0] s,
                            input logic st, input logic ab);
    m_done = 1'b0;
    if (!m_scan) begin
      if (st && m) begin
        m_scan = 1'b1;
        m_k    = 0;
        m_idx  = 0;
        m_y    = W'(1);
      end else if (e) begin
        m_idx = int'(s);
        m_y   = W'(1) << s;
      end else begin
        m_y = '0;
      end
    end else if (ab) begin
      m_scan = 1'b0;
      m_y    = '0;
    end else if (e) begin
      m_k++;
      if (m_k == int'(DWELL * W)) begin
        m_scan = 1'b0;
        m_y    = '0;
        m_done = 1'b1;
      end else begin
        m_idx = m_k / int'(DWELL);
        m_y   = W'(1) << m_idx;
      end
    end
  endtask

  task automatic compare_model();
    chk("y", 32'(bus.y), 32'(pin_y(m_y)));
    chk("busy", 32'(bus.busy), 32'(m_scan));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("onehot0", 32'($onehot0(pin_y(bus.y))), 32'd1);
    if (m_y != '0) chk("y_idx", 32'(bus.y_idx), 32'(m_idx));
  endtask

  // Drive inputs away from the edge, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic e, input logic m, input logic [N-1:0] s,
                      input logic st, input logic ab);
    bus.en    = e;
    bus.mode  = m;
    bus.sel   = s;
    bus.start = st;
    bus.abort = ab;
    @(posedge clk);
    model_step(e, m, s, st, ab);
    @(negedge clk);
    compare_model();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_y", 32'(bus.y), 32'(pin_y(4'b0000)));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_idx", 32'(bus.y_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] scan_exp [12];

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.sel   = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    model_reset();
    scan_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_model();

    // DIRECT decode and off.
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    chk("direct_y_sel2", 32'(bus.y), 32'(pin_y(4'b0100)));
    chk("direct_idx_sel2", 32'(bus.y_idx), 32'd2);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("direct_off", 32'(bus.y), 32'(pin_y(4'b0000)));
    step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    chk("direct_y_sel1", 32'(bus.y), 32'(pin_y(4'b0010)));
    // start with mode=0 is ignored; top index decodes.
    step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("start_mode0_y", 32'(bus.y), 32'(pin_y(4'b1000)));
    chk("start_mode0_busy", 32'(bus.busy), 32'd0);
    // abort in IDLE has no effect.
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("abort_idle_y", 32'(bus.y), 32'(pin_y(4'b0001)));

    // Full scan, start has priority over DIRECT.
    step(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    chk("scan_y_0", 32'(bus.y), 32'(pin_y(scan_exp[0])));
    chk("scan_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("scan_y", 32'(bus.y), 32'(pin_y(scan_exp[i])));
    end
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("scan_end_y", 32'(bus.y), 32'(pin_y(4'b0000)));
    chk("scan_end_done", 32'(bus.done), 32'd1);
    chk("scan_end_busy", 32'(bus.busy), 32'd0);
    // start on the done cycle: new scan next edge.
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("b2b_y", 32'(bus.y), 32'(pin_y(4'b0001)));
    chk("b2b_done", 32'(bus.done), 32'd0);
    // start while busy ignored.
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("restart_ignored", 32'(bus.y), 32'(pin_y(4'b0010)));
    // Pause two cycles at 0010.
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("pause_y", 32'(bus.y), 32'(pin_y(4'b0010)));
    chk("pause_idx", 32'(bus.y_idx), 32'd1);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("resume_y", 32'(bus.y), 32'(pin_y(4'b0010)));
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("resume_adv", 32'(bus.y), 32'(pin_y(4'b0100)));
    // Abort beats en.
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("abort_y", 32'(bus.y), 32'(pin_y(4'b0000)));
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);

    // Reset mid-scan.
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    do_reset();
    compare_model();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      logic e, m, st, ab;
      logic [N-1:0] s;
      e  = ($urandom_range(0, 3) != 0);
      m  = $urandom_range(0, 1) == 1;
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 39) == 0);
      s  = N'($urandom_range(0, W - 1));
      step(e, m, s, st, ab);
      if (c == 1000) begin
        do_reset();
        compare_model();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
